maj_tt_sweeper: RTL
===================

Name: maj_tt_sweeper

Overview:
- Sequenced truth-table extractor for majority-gate networks.
- Holds a small program of MAJ3 gate descriptors and evaluates them serially on one shared MAJ3 unit, one gate per clock.
- Sweeps all 2^NUM_IN input assignments and returns the full truth table.
- Used by classification flows to obtain the hex signature of a candidate network without building it in fabric.

Parameters:
- NUM_IN, 7, primary inputs. Truth table width TT_W = 2^NUM_IN.
- MAX_GATES, 16, program capacity in gates.
- NODE_W, clog2(1+NUM_IN+MAX_GATES) = 5, width of a node index.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- prog_we  in  1  program write strobe
- prog_addr  in  clog2(MAX_GATES)  gate slot to write
- prog_data  in  3*(NODE_W+1)  gate descriptor {inv2,idx2,inv1,idx1,inv0,idx0}, operand 0 in the LSBs
- num_gates  in  clog2(MAX_GATES)+1  gate count N, sampled at start
- out_sel  in  NODE_W  output node index, sampled at start
- out_inv  in  1  invert the output, sampled at start
- start  in  1  request a sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  last start was rejected
- tt  out  TT_W  truth table; bit p = f(assignment p), x0 = bit 0 of p
- tt_valid  out  1  tt holds a completed sweep

Behaviour:
- Reset values: busy=0, done=0, cfg_err=0, tt=0, tt_valid=0, state=IDLE. The program RAM is not reset.
- Node space:
  - 0 = constant 0.
  - 1..NUM_IN = x0..x(NUM_IN-1), taken from the pattern counter p.
  - NUM_IN+1+g = output of gate g.
  - Operand value = node value XOR inv bit, so inv with idx 0 gives constant 1.
- Gate g computes MAJ(a,b,c) = ab|ac|bc over its three operands and writes node NUM_IN+1+g.
- Causality rule: an operand indexing a gate node >= the gate currently being evaluated in this pattern reads 0 before the inv bit is applied. This also covers indices beyond N and out-of-range indices.
- Program writes are accepted only in IDLE. Writes while busy are ignored.
- States: IDLE, EVAL, COMMIT, FIN.
- IDLE, start=1:
  - If N==0, N>MAX_GATES, or out_sel > NUM_IN+N: cfg_err<=1 and stay in IDLE.
  - Otherwise: cfg_err<=0, tt<=0, tt_valid<=0, busy<=1, latch N, out_sel and out_inv, p<=0, g<=0, go to EVAL.
- EVAL: evaluate gate g. If g==N-1, go to COMMIT; otherwise g<=g+1.
- COMMIT:
  - tt[p] <= node[out_sel] ^ out_inv, g<=0.
  - If p==TT_W-1, go to FIN; otherwise p<=p+1 and go to EVAL.
- FIN: done=1 for this cycle only, busy<=0, tt_valid<=1, go to IDLE.
- Timing:
  - Each pattern costs N+1 cycles.
  - busy rises on the edge that samples start.
  - done is high in the cycle beginning 128*(N+1)+1 edges after the start edge. For N=5 this is 769.
- start while busy is ignored and does not set cfg_err.
- p wraps are impossible: the sweep ends at p=TT_W-1.
- Asynchronous reset mid-sweep forces IDLE immediately and clears tt/tt_valid. The next start must run a full sweep.
- done and start in the same cycle: FIN ignores start; it is accepted only in the following IDLE cycle.

Decomposition:
- Package maj_tt_pkg holds:
  - NUM_IN, NODE_W and the node-base constants (NODE_CONST0=0, NODE_IN0=1, NODE_GATE0=NUM_IN+1).
  - The gate_desc_t struct (three {inv, idx} operand fields).
  - The state enum.
- Sub-module maj_tt_opsel: combinational operand fetch. It applies the causality mask and inversion and drives the MAJ3 result. It is instantiated once and is the only MAJ hardware.
- The program RAM, node register file, counters and FSM stay in the top module.

Test Plan:
- Program the 5-gate network below, N=5, out_sel=12, out_inv=0, start -> done at 769 cycles, tt = 128'hfeeaeaa8eaa8a880feeaeaa8eaa8a880.
  - g0 = MAJ(x0,x1,x3), g1 = MAJ(x1,x2,x3), g2 = MAJ(x0,x2,g0), g3 = MAJ(x0,x4,g1), g4 = MAJ(x5,g2,g3).
- Single gate MAJ(x0,x1,x2), out_sel=8: tt is 128'hE8 repeated across every byte. Repeat with out_inv=1: every byte becomes 17.
- Gate 0 = MAJ(x0, idx0, idx0 with inv) (constant 0 and constant 1), out_sel=8: tt equals the x0 pattern, 128'hAAAA..AA. Then make gate 0 reference node 9 (forward reference): tt equals MAJ(x0,0,1) = x0, with no X in the table.
- start with N=0, then with out_sel=20 at N=3 -> cfg_err=1, busy stays 0, tt_valid unchanged. A valid start afterwards clears cfg_err.
- Assert reset at cycle 300 of a sweep -> busy, tt and tt_valid go to 0 asynchronously. A restart gives an identical tt and done latency.
- Issue prog_we and start while busy -> program and timing unaffected. Read back by re-sweeping in IDLE gives the same tt.

Source files
------------

// File: rtl/maj_tt_pkg.sv
// Shared constants, gate descriptor layout and FSM encoding for the MAJ3
// truth-table sweeper.
package maj_tt_pkg;

  localparam int NUM_IN      = 7;
  localparam int MAX_GATES   = 16;
  localparam int TT_W        = 1 << NUM_IN;
  localparam int NODE_W      = $clog2(1 + NUM_IN + MAX_GATES);
  localparam int ADDR_W      = $clog2(MAX_GATES);
  localparam int GCNT_W      = ADDR_W + 1;

  localparam int NODE_CONST0 = 0;
  localparam int NODE_IN0    = 1;
  localparam int NODE_GATE0  = NUM_IN + 1;

  typedef struct packed {
    logic              inv;
    logic [NODE_W-1:0] idx;
  } operand_t;

  // Operand 0 sits in the LSBs of the descriptor word.
  typedef struct packed {
    operand_t op2;
    operand_t op1;
    operand_t op0;
  } gate_desc_t;

  localparam int DESC_W = $bits(gate_desc_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_COMMIT,
    ST_FIN
  } state_t;

  // Value of a node for the current pattern. Gate nodes at or beyond
  // 'limit' have not been produced yet in this pattern and read as 0.
  function automatic logic node_value(
    input logic [NODE_W-1:0]    idx,
    input logic [NUM_IN-1:0]    pat,
    input logic [MAX_GATES-1:0] gate_val,
    input logic [GCNT_W-1:0]    limit
  );
    logic v;
    v = 1'b0;
    if (idx == NODE_W'(NODE_CONST0)) v = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (idx == NODE_W'(NODE_IN0 + i)) v = pat[i];
    end
    for (int k = 0; k < MAX_GATES; k++) begin
      if ((idx == NODE_W'(NODE_GATE0 + k)) && (GCNT_W'(k) < limit)) v = gate_val[k];
    end
    return v;
  endfunction

endpackage

// File: rtl/maj_tt_opsel.sv
// Operand fetch for one gate: causality mask, per-operand inversion and the
// single shared MAJ3.
module maj_tt_opsel
  import maj_tt_pkg::*;
(
  input  gate_desc_t           desc,
  input  logic [NUM_IN-1:0]    pat,
  input  logic [MAX_GATES-1:0] gate_val,
  input  logic [GCNT_W-1:0]    limit,
  output logic                 maj
);

  logic a, b, c;

  always_comb begin
    a   = node_value(desc.op0.idx, pat, gate_val, limit) ^ desc.op0.inv;
    b   = node_value(desc.op1.idx, pat, gate_val, limit) ^ desc.op1.inv;
    c   = node_value(desc.op2.idx, pat, gate_val, limit) ^ desc.op2.inv;
    maj = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/maj_tt_sweeper.sv
// Serial truth-table extractor: evaluates a stored MAJ3 program one gate per
// clock for every input pattern and collects the selected node into tt.
module maj_tt_sweeper
  import maj_tt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DESC_W-1:0] prog_data,
  input  logic [GCNT_W-1:0] num_gates,
  input  logic [NODE_W-1:0] out_sel,
  input  logic              out_inv,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [TT_W-1:0]   tt,
  output logic              tt_valid
);

  gate_desc_t prog_mem_q [MAX_GATES];

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [TT_W-1:0]      tt_q, tt_d;
  logic                 tt_valid_q, tt_valid_d;
  logic [GCNT_W-1:0]    num_q, num_d;
  logic [NODE_W-1:0]    sel_q, sel_d;
  logic                 inv_q, inv_d;
  logic [NUM_IN-1:0]    p_q, p_d;
  logic [ADDR_W-1:0]    g_q, g_d;
  logic [MAX_GATES-1:0] gate_val_q, gate_val_d;

  logic cfg_bad;
  logic gate_out;
  logic out_bit;

  // The program may only change between sweeps.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == ST_IDLE)) prog_mem_q[prog_addr] <= gate_desc_t'(prog_data);
  end

  maj_tt_opsel u_opsel (
    .desc     (prog_mem_q[g_q]),
    .pat      (p_q),
    .gate_val (gate_val_q),
    .limit    (GCNT_W'(g_q)),
    .maj      (gate_out)
  );

  assign cfg_bad = (num_gates == '0)
                || (num_gates > GCNT_W'(MAX_GATES))
                || ({1'b0, out_sel} > ((NODE_W+1)'(NUM_IN) + (NODE_W+1)'(num_gates)));

  // At COMMIT every gate below N holds this pattern's value.
  assign out_bit = node_value(sel_q, p_q, gate_val_q, num_q) ^ inv_q;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cfg_err_d  = cfg_err_q;
    tt_d       = tt_q;
    tt_valid_d = tt_valid_q;
    num_d      = num_q;
    sel_d      = sel_q;
    inv_d      = inv_q;
    p_d        = p_q;
    g_d        = g_q;
    gate_val_d = gate_val_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d  = 1'b0;
            tt_d       = '0;
            tt_valid_d = 1'b0;
            busy_d     = 1'b1;
            num_d      = num_gates;
            sel_d      = out_sel;
            inv_d      = out_inv;
            p_d        = '0;
            g_d        = '0;
            state_d    = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        gate_val_d[g_q] = gate_out;
        if ({1'b0, g_q} == (num_q - GCNT_W'(1))) state_d = ST_COMMIT;
        else g_d = g_q + ADDR_W'(1);
      end
      ST_COMMIT: begin
        tt_d[p_q] = out_bit;
        g_d       = '0;
        if (p_q == '1) begin
          state_d = ST_FIN;
        end else begin
          p_d     = p_q + NUM_IN'(1);
          state_d = ST_EVAL;
        end
      end
      ST_FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        tt_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      tt_q       <= '0;
      tt_valid_q <= 1'b0;
      num_q      <= '0;
      sel_q      <= '0;
      inv_q      <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gate_val_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      tt_q       <= tt_d;
      tt_valid_q <= tt_valid_d;
      num_q      <= num_d;
      sel_q      <= sel_d;
      inv_q      <= inv_d;
      p_q        <= p_d;
      g_q        <= g_d;
      gate_val_q <= gate_val_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign tt       = tt_q;
  assign tt_valid = tt_valid_q;

endmodule
